// File: rtl/morra_cinese_pkg.sv
// ============================================================================
// morra_cinese_pkg : move codes, result codes and FSM state type
// Rev 1.0
// ============================================================================
`default_nettype none

package morra_cinese_pkg;

  localparam logic [1:0] c_move_none     = 2'b00;
  localparam logic [1:0] c_move_rock     = 2'b01;
  localparam logic [1:0] c_move_paper    = 2'b10;
  localparam logic [1:0] c_move_scissors = 2'b11;

  localparam logic [1:0] c_res_none = 2'b00;
  localparam logic [1:0] c_res_p1   = 2'b01;
  localparam logic [1:0] c_res_p2   = 2'b10;
  localparam logic [1:0] c_res_tie  = 2'b11;

  localparam logic [4:0] MIN_MANCHE = 5'd4;
  localparam logic [4:0] BASE_MAX   = 5'd4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/morra_cinese_if.sv
// ============================================================================
// morra_cinese_if : player moves / start strobe in, round and game result out
// Rev 1.0
// ============================================================================
`default_nettype none

interface morra_cinese_if;
  logic       INIZIO;
  logic [1:0] PRIMO;
  logic [1:0] SECONDO;
  logic [1:0] MANCHE;
  logic [1:0] PARTITA;

  modport master (output INIZIO, PRIMO, SECONDO, input MANCHE, PARTITA);
  modport slave  (input INIZIO, PRIMO, SECONDO, output MANCHE, PARTITA);
endinterface

`default_nettype wire

// File: rtl/morra_cinese_judge.sv
// ============================================================================
// morra_judge : combinational rock/paper/scissors outcome of one round
// Rev 1.0
// ============================================================================
`default_nettype none

module morra_judge
  import morra_cinese_pkg::*;
(
  input  logic [1:0] i_primo,
  input  logic [1:0] i_secondo,
  output logic [1:0] o_esito
);

  logic w_p1_beats;

  assign w_p1_beats = ((i_primo == c_move_rock)     && (i_secondo == c_move_scissors)) ||
                      ((i_primo == c_move_scissors) && (i_secondo == c_move_paper))    ||
                      ((i_primo == c_move_paper)    && (i_secondo == c_move_rock));

  always_comb begin
    o_esito = c_res_p2;
    if ((i_primo == c_move_none) || (i_secondo == c_move_none)) begin
      o_esito = c_res_none;
    end else if (i_primo == i_secondo) begin
      o_esito = c_res_tie;
    end else if (w_p1_beats) begin
      o_esito = c_res_p1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/morra_cinese.sv
// ============================================================================
// morra_cinese : best-of-N morra game controller with registered results
// Rev 1.0
// ============================================================================
`default_nettype none

module morra_cinese
  import morra_cinese_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  morra_cinese_if.slave bus
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [4:0] r_max;
  logic [4:0] r_played;
  logic [4:0] r_w1;
  logic [4:0] r_w2;
  logic [1:0] r_last_win;
  logic [1:0] r_last_move;
  logic [1:0] r_manche;
  logic [1:0] r_partita;

  logic [1:0] w_esito;
  logic       w_repeat;
  logic       w_valid;
  logic [4:0] w_played_nxt;
  logic [4:0] w_w1_nxt;
  logic [4:0] w_w2_nxt;
  logic       w_diff_ok;
  logic       w_end;
  logic [1:0] w_manche_nxt;
  logic [1:0] w_partita_nxt;

  morra_judge u_judge (
    .i_primo   (bus.PRIMO),
    .i_secondo (bus.SECONDO),
    .o_esito   (w_esito)
  );

  // The last non-tie winner may not replay the move that won
  assign w_repeat = ((r_last_win == c_res_p1) && (bus.PRIMO   == r_last_move)) ||
                    ((r_last_win == c_res_p2) && (bus.SECONDO == r_last_move));

  assign w_valid = (r_state == ST_PLAY) && !bus.INIZIO &&
                   (w_esito != c_res_none) && !w_repeat;

  assign w_played_nxt = r_played + 5'd1;
  assign w_w1_nxt     = (w_esito == c_res_p1) ? r_w1 + 5'd1 : r_w1;
  assign w_w2_nxt     = (w_esito == c_res_p2) ? r_w2 + 5'd1 : r_w2;
  assign w_diff_ok    = (w_w1_nxt >= w_w2_nxt) ? ((w_w1_nxt - w_w2_nxt) >= 5'd2)
                                               : ((w_w2_nxt - w_w1_nxt) >= 5'd2);
  assign w_end        = w_valid && (((w_played_nxt >= MIN_MANCHE) && w_diff_ok) ||
                                    (w_played_nxt == r_max));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.INIZIO) begin
      w_state_nxt = ST_PLAY;
    end else if ((r_state == ST_PLAY) && w_end) begin
      w_state_nxt = ST_IDLE;
    end
  end

  always_comb begin
    w_manche_nxt  = w_valid ? w_esito : c_res_none;
    w_partita_nxt = c_res_none;
    if (w_end) begin
      if (w_w1_nxt > w_w2_nxt) begin
        w_partita_nxt = c_res_p1;
      end else if (w_w2_nxt > w_w1_nxt) begin
        w_partita_nxt = c_res_p2;
      end else begin
        w_partita_nxt = c_res_tie;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_max       <= 5'd0;
      r_played    <= 5'd0;
      r_w1        <= 5'd0;
      r_w2        <= 5'd0;
      r_last_win  <= c_res_none;
      r_last_move <= c_move_none;
      r_manche    <= c_res_none;
      r_partita   <= c_res_none;
    end else begin
      r_manche  <= w_manche_nxt;
      r_partita <= w_partita_nxt;
      if (bus.INIZIO) begin
        r_max       <= BASE_MAX + {1'b0, bus.PRIMO, bus.SECONDO};
        r_played    <= 5'd0;
        r_w1        <= 5'd0;
        r_w2        <= 5'd0;
        r_last_win  <= c_res_none;
        r_last_move <= c_move_none;
      end else if (w_valid) begin
        r_played <= w_played_nxt;
        r_w1     <= w_w1_nxt;
        r_w2     <= w_w2_nxt;
        if (w_esito == c_res_tie) begin
          r_last_win  <= c_res_none;
          r_last_move <= c_move_none;
        end else begin
          r_last_win  <= w_esito;
          r_last_move <= (w_esito == c_res_p1) ? bus.PRIMO : bus.SECONDO;
        end
      end
    end
  end

  assign bus.MANCHE  = r_manche;
  assign bus.PARTITA = r_partita;

endmodule

`default_nettype wire

// File: tb/tb_morra_cinese.sv
// ============================================================================
// tb_morra_cinese : directed vectors with a queue-based result scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_morra_cinese;

  logic clk;
  logic rst_n;
  logic drv_valid;
  int   checks;
  int   errors;

  logic [3:0] exp_q[$];
  string      name_q[$];

  morra_cinese_if bus ();

  morra_cinese dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs and record the {MANCHE,PARTITA} it must produce
  task automatic apply(input string nm, input logic ini, input logic [1:0] p,
                       input logic [1:0] s, input logic [1:0] em, input logic [1:0] ep);
    @(negedge clk);
    bus.INIZIO  = ini;
    bus.PRIMO   = p;
    bus.SECONDO = s;
    drv_valid   = 1'b1;
    exp_q.push_back({em, ep});
    name_q.push_back(nm);
  endtask

  task automatic idle_bus();
    @(negedge clk);
    bus.INIZIO  = 1'b0;
    bus.PRIMO   = 2'b00;
    bus.SECONDO = 2'b00;
    drv_valid   = 1'b0;
  endtask

  task automatic check_now(input string nm, input logic [3:0] req);
    checks++;
    if ({bus.MANCHE, bus.PARTITA} !== req) begin
      errors++;
      $display("FAIL %s: got MANCHE/PARTITA=%b/%b required %b/%b",
               nm, bus.MANCHE, bus.PARTITA, req[3:2], req[1:0]);
    end
  endtask

  // Monitor: every cycle that carried a vector yields one result to compare
  initial begin : monitor
    logic       v;
    logic [3:0] e;
    string      nm;
    forever begin
      @(posedge clk);
      v = drv_valid;
      #1;
      if (v) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_empty: got %b/%b with no expectation",
                   bus.MANCHE, bus.PARTITA);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          if ({bus.MANCHE, bus.PARTITA} !== e) begin
            errors++;
            $display("FAIL %s: got MANCHE/PARTITA=%b/%b required %b/%b",
                     nm, bus.MANCHE, bus.PARTITA, e[3:2], e[1:0]);
          end
        end
      end
    end
  end

  initial begin : driver
    checks      = 0;
    errors      = 0;
    drv_valid   = 1'b0;
    rst_n       = 1'b0;
    bus.INIZIO  = 1'b0;
    bus.PRIMO   = 2'b00;
    bus.SECONDO = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check_now("reset_state", 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    apply("idle_ignores_moves", 1'b0, 2'b01, 2'b11, 2'b00, 2'b00);

    // P1 sweep with a rejected repeat of the winning move
    apply("g1_cfg",  1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
    apply("g1_r1",   1'b0, 2'b01, 2'b11, 2'b01, 2'b00);
    apply("g1_rep",  1'b0, 2'b01, 2'b11, 2'b00, 2'b00);
    apply("g1_r2",   1'b0, 2'b10, 2'b01, 2'b01, 2'b00);
    apply("g1_r3",   1'b0, 2'b11, 2'b10, 2'b01, 2'b00);
    apply("g1_end",  1'b0, 2'b01, 2'b11, 2'b01, 2'b01);

    // Four ties reach max_manche=4
    apply("g2_cfg",  1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
    apply("g2_t1",   1'b0, 2'b01, 2'b01, 2'b11, 2'b00);
    apply("g2_t2",   1'b0, 2'b10, 2'b10, 2'b11, 2'b00);
    apply("g2_t3",   1'b0, 2'b11, 2'b11, 2'b11, 2'b00);
    apply("g2_end",  1'b0, 2'b01, 2'b01, 2'b11, 2'b11);
    apply("g2_idle", 1'b0, 2'b01, 2'b11, 2'b00, 2'b00);

    // Winner may not replay paper; no-move rounds are void
    apply("g3_cfg",  1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
    apply("g3_r1",   1'b0, 2'b10, 2'b01, 2'b01, 2'b00);
    apply("g3_rep1", 1'b0, 2'b10, 2'b11, 2'b00, 2'b00);
    apply("g3_rep2", 1'b0, 2'b10, 2'b11, 2'b00, 2'b00);
    apply("g3_nomv", 1'b0, 2'b00, 2'b10, 2'b00, 2'b00);
    apply("g3_r2",   1'b0, 2'b11, 2'b10, 2'b01, 2'b00);

    // max_manche=5 ends the game with a one-point lead
    apply("g4_cfg",  1'b1, 2'b00, 2'b01, 2'b00, 2'b00);
    apply("g4_r1",   1'b0, 2'b01, 2'b10, 2'b10, 2'b00);
    apply("g4_rep",  1'b0, 2'b11, 2'b10, 2'b00, 2'b00);
    apply("g4_r2",   1'b0, 2'b10, 2'b01, 2'b01, 2'b00);
    apply("g4_t1",   1'b0, 2'b01, 2'b01, 2'b11, 2'b00);
    apply("g4_t2",   1'b0, 2'b10, 2'b10, 2'b11, 2'b00);
    apply("g4_end",  1'b0, 2'b01, 2'b11, 2'b01, 2'b01);

    // P2 wins on a two-point lead after four rounds
    apply("g5_cfg",  1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
    apply("g5_r1",   1'b0, 2'b01, 2'b10, 2'b10, 2'b00);
    apply("g5_r2",   1'b0, 2'b11, 2'b01, 2'b10, 2'b00);
    apply("g5_r3",   1'b0, 2'b11, 2'b10, 2'b01, 2'b00);
    apply("g5_end",  1'b0, 2'b10, 2'b11, 2'b10, 2'b10);

    // Asynchronous reset mid-game
    apply("g6_cfg",  1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
    apply("g6_r1",   1'b0, 2'b01, 2'b11, 2'b01, 2'b00);
    idle_bus();
    rst_n = 1'b0;
    #1;
    check_now("async_reset", 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    apply("g6_post1", 1'b0, 2'b10, 2'b01, 2'b00, 2'b00);
    apply("g6_post2", 1'b0, 2'b01, 2'b11, 2'b00, 2'b00);

    // Restart mid-game discards the earlier win
    apply("g7_cfg",  1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
    apply("g7_old",  1'b0, 2'b01, 2'b11, 2'b01, 2'b00);
    apply("g7_rcfg", 1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
    apply("g7_r1",   1'b0, 2'b10, 2'b01, 2'b01, 2'b00);
    apply("g7_r2",   1'b0, 2'b11, 2'b10, 2'b01, 2'b00);
    apply("g7_r3",   1'b0, 2'b01, 2'b11, 2'b01, 2'b00);
    apply("g7_end",  1'b0, 2'b10, 2'b01, 2'b01, 2'b01);
    idle_bus();

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
